vec_cmd_issue: RTL and testbench

//  Upstream command stage for the vector accelerator top. Buffers packed vector instructions
//  (plus write data) in a small FIFO and decodes/validates each one. Issues them one at a time

---
 rtl/vec_pkg.sv | 42 ++++
 rtl/bsg_fifo_1r1w_small.sv | 58 +++++
 rtl/vec_cmd_issue.sv | 159 +++++++++++++++
 tb/tb_vec_cmd_issue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types for the vector command issue stage: opcodes, packed instruction layout
// and the opcode legality check used before a command is handed to the core.
package vec_pkg;

   localparam int VEC_ADDR_W = 4;
   localparam int VEC_VDW    = 4;

   typedef enum logic [3:0] {
      ADD   = 4'b0000,
      SUB   = 4'b0001,
      MUL   = 4'b0010,
      SADD  = 4'b0100,
      SSUB  = 4'b0101,
      SMUL  = 4'b0110,
      READ  = 4'b1000,
      WRITE = 4'b1001,
      DOT   = 4'b1111
   } vec_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } issue_state_e;

   // Host-side instruction layout for the default geometry, MSB first.
   typedef struct packed {
      logic [3:0]            op;
      logic [VEC_ADDR_W-1:0] addr_d;
      logic [VEC_ADDR_W-1:0] addr_b;
      logic [VEC_ADDR_W-1:0] addr_a;
      logic [VEC_VDW-1:0]    scalar;
   } vec_instr_s;

   function automatic logic vec_op_legal(logic [3:0] op);
      logic ok;
      if (op[3] == 1'b0) ok = (op[1:0] != 2'b11);
      else               ok = (op == READ) || (op == WRITE) || (op == DOT);
      return ok;
   endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO with valid/ready in and valid/yumi out.
// No bypass: a full queue refuses new data even when it is being drained in the same cycle.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 8,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

   logic [width_p-1:0]  mem_q [els_p];
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic                enq, deq;

   assign ready_o = reset_n_i & (cnt_q != full_cnt_lp);
   assign v_o     = (cnt_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (enq) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/vec_cmd_issue.sv
// Command stage in front of the vector core: queues host instructions, drops illegal ops,
// issues one command at a time and skids core read results back to the host.
module vec_cmd_issue
   import vec_pkg::*;
#(
   parameter int els_p      = 10,
   parameter int vlen_p     = 4,
   parameter int vdw_p      = 4,
   parameter int fifo_els_p = 4,
   localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int instr_w_lp = 4 + 3 * addr_w_lp + vdw_p,
   localparam int data_w_lp  = vlen_p * vdw_p
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  instr_v_i,
   input  logic [instr_w_lp-1:0] instr_i,
   input  logic [data_w_lp-1:0]  wdata_i,
   output logic                  instr_ready_o,
   output logic [3:0]            op_o,
   output logic [addr_w_lp-1:0]  addrA_o,
   output logic [addr_w_lp-1:0]  addrB_o,
   output logic [addr_w_lp-1:0]  addrD_o,
   output logic [vdw_p-1:0]      scalar_o,
   output logic [data_w_lp-1:0]  w_data_o,
   output logic                  cmd_v_o,
   input  logic                  cmd_ready_i,
   input  logic                  done_i,
   input  logic                  core_v_i,
   input  logic [data_w_lp-1:0]  core_rdata_i,
   output logic                  core_yumi_o,
   output logic                  rdata_v_o,
   output logic [data_w_lp-1:0]  rdata_o,
   input  logic                  rdata_yumi_i,
   output logic                  busy_o,
   output logic                  illegal_o
);

   localparam int fifo_w_lp = instr_w_lp + data_w_lp;
   localparam int sc_lsb_lp = data_w_lp;
   localparam int a_lsb_lp  = sc_lsb_lp + vdw_p;
   localparam int b_lsb_lp  = a_lsb_lp + addr_w_lp;
   localparam int d_lsb_lp  = b_lsb_lp + addr_w_lp;

   logic                 fifo_v, fifo_yumi;
   logic [fifo_w_lp-1:0] fifo_data;

   bsg_fifo_1r1w_small #(.width_p(fifo_w_lp), .els_p(fifo_els_p)) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (instr_v_i),
      .ready_o   (instr_ready_o),
      .data_i    ({instr_i, wdata_i}),
      .v_o       (fifo_v),
      .data_o    (fifo_data),
      .yumi_i    (fifo_yumi)
   );

   logic [3:0] head_op;
   logic       head_legal;
   assign head_op    = fifo_data[fifo_w_lp-1 -: 4];
   assign head_legal = fifo_v & vec_op_legal(head_op);

   issue_state_e         state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [addr_w_lp-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_d_q, addr_d_d;
   logic [vdw_p-1:0]     scalar_q, scalar_d;
   logic [data_w_lp-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic                 illegal_q, illegal_d, rdata_v_q, rdata_v_d;
   logic                 load;

   // Illegal heads are only dropped from IDLE; a done_i with an illegal head returns there first.
   always_comb begin
      state_d   = state_q;
      fifo_yumi = 1'b0;
      load      = 1'b0;
      illegal_d = 1'b0;
      unique case (state_q)
         ST_IDLE: if (fifo_v) begin
            fifo_yumi = 1'b1;
            if (head_legal) begin
               load    = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               illegal_d = 1'b1;
            end
         end
         ST_ISSUE: if (cmd_ready_i) state_d = ST_WAIT;
         ST_WAIT: if (done_i) begin
            if (head_legal) begin
               fifo_yumi = 1'b1;
               load      = 1'b1;
               state_d   = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d     = load ? head_op : op_q;
      addr_a_d = load ? fifo_data[a_lsb_lp +: addr_w_lp] : addr_a_q;
      addr_b_d = load ? fifo_data[b_lsb_lp +: addr_w_lp] : addr_b_q;
      addr_d_d = load ? fifo_data[d_lsb_lp +: addr_w_lp] : addr_d_q;
      scalar_d = load ? fifo_data[sc_lsb_lp +: vdw_p] : scalar_q;
      wdata_d  = load ? fifo_data[data_w_lp-1:0] : wdata_q;
      // Load has priority over consume, though yumi is never offered while the skid is full.
      rdata_v_d = rdata_v_q;
      rdata_d   = rdata_q;
      if (core_v_i && core_yumi_o) begin
         rdata_v_d = 1'b1;
         rdata_d   = core_rdata_i;
      end else if (rdata_yumi_i) begin
         rdata_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         addr_d_q  <= '0;
         scalar_q  <= '0;
         wdata_q   <= '0;
         illegal_q <= 1'b0;
         rdata_v_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         addr_d_q  <= addr_d_d;
         scalar_q  <= scalar_d;
         wdata_q   <= wdata_d;
         illegal_q <= illegal_d;
         rdata_v_q <= rdata_v_d;
         rdata_q   <= rdata_d;
      end
   end

   assign op_o        = op_q;
   assign addrA_o     = addr_a_q;
   assign addrB_o     = addr_b_q;
   assign addrD_o     = addr_d_q;
   assign scalar_o    = scalar_q;
   assign w_data_o    = wdata_q;
   assign cmd_v_o     = (state_q == ST_ISSUE);
   assign core_yumi_o = reset_n_i & ~rdata_v_q;
   assign rdata_v_o   = rdata_v_q;
   assign rdata_o     = rdata_q;
   assign illegal_o   = illegal_q;
   assign busy_o      = fifo_v | (state_q != ST_IDLE);

endmodule

// File: tb/tb_vec_cmd_issue.sv
// Directed bench for vec_cmd_issue: a hand-driven core model and hand-computed expectations.
module tb_vec_cmd_issue;
  import vec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_v_i;
  logic [19:0] instr_i;
  logic [15:0] wdata_i;
  logic        instr_ready_o;
  logic [3:0]  op_o, addrA_o, addrB_o, addrD_o, scalar_o;
  logic [15:0] w_data_o;
  logic        cmd_v_o, cmd_ready_i, done_i, core_v_i, core_yumi_o;
  logic [15:0] core_rdata_i;
  logic        rdata_v_o, rdata_yumi_i, busy_o, illegal_o;
  logic [15:0] rdata_o;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int ill_cnt = 0;

  vec_cmd_issue dut (
    .clk_i(clk), .reset_n_i(rst_n), .instr_v_i(instr_v_i), .instr_i(instr_i),
    .wdata_i(wdata_i), .instr_ready_o(instr_ready_o), .op_o(op_o), .addrA_o(addrA_o),
    .addrB_o(addrB_o), .addrD_o(addrD_o), .scalar_o(scalar_o), .w_data_o(w_data_o),
    .cmd_v_o(cmd_v_o), .cmd_ready_i(cmd_ready_i), .done_i(done_i), .core_v_i(core_v_i),
    .core_rdata_i(core_rdata_i), .core_yumi_o(core_yumi_o), .rdata_v_o(rdata_v_o),
    .rdata_o(rdata_o), .rdata_yumi_i(rdata_yumi_i), .busy_o(busy_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // Count handshakes and illegal pulses once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (cmd_v_o && cmd_ready_i) hs_cnt++;
    if (illegal_o) ill_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] b, input logic [3:0] a,
                                     input logic [3:0] s);
    vec_instr_s x;
    x.op = op; x.addr_d = d; x.addr_b = b; x.addr_a = a; x.scalar = s;
    return x;
  endfunction

  task automatic enq(input logic [19:0] ins, input logic [15:0] wd);
    int n = 0;
    instr_v_i = 1'b1; instr_i = ins; wdata_i = wd;
    while (!instr_ready_o && n < 50) begin tick(); n++; end
    chk("enq_ready", instr_ready_o, 1'b1);
    tick();
    instr_v_i = 1'b0;
  endtask

  task automatic pulse_done();
    done_i = 1'b1; tick(); done_i = 1'b0;
  endtask

  initial begin
    int hs0, ill0;
    logic [15:0] exp_wd;
    rst_n = 1'b0; instr_v_i = 0; instr_i = '0; wdata_i = '0; cmd_ready_i = 0;
    done_i = 0; core_v_i = 0; core_rdata_i = '0; rdata_yumi_i = 0;
    #12;
    chk("rst_cmd_v", cmd_v_o, 0);
    chk("rst_ready", instr_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_yumi", core_yumi_o, 0);
    chk("rst_rdata_v", rdata_v_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_op", op_o, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("ready_after_rst", instr_ready_o, 1);

    // WRITE: one cycle in the queue, then ISSUE; done three cycles after accept.
    enq(mk(WRITE, 4'd1, 4'd0, 4'd0, 4'd0), 16'h4321);
    chk("wr_lat_cmd_v0", cmd_v_o, 0);
    chk("wr_busy_q", busy_o, 1);
    tick();
    chk("wr_cmd_v", cmd_v_o, 1);
    chk("wr_op", op_o, 4'b1001);
    chk("wr_addrD", addrD_o, 1);
    chk("wr_wdata", w_data_o, 16'h4321);
    cmd_ready_i = 1; tick(); cmd_ready_i = 0;
    chk("wr_wait_cmd_v", cmd_v_o, 0);
    tick(); tick();
    done_i = 1;
    chk("wr_busy_pre_done", busy_o, 1);
    tick(); done_i = 0;
    chk("wr_busy_after_done", busy_o, 0);

    // READ with one-entry skid; a second core result stalls until the host consumes.
    enq(mk(READ, 4'd0, 4'd0, 4'd5, 4'd0), 16'h0);
    tick();
    chk("rd_cmd_v", cmd_v_o, 1);
    chk("rd_op", op_o, 4'b1000);
    chk("rd_addrA", addrA_o, 5);
    cmd_ready_i = 1; tick(); cmd_ready_i = 0;
    chk("rd_yumi_empty", core_yumi_o, 1);
    core_v_i = 1; core_rdata_i = 16'h8888; tick();
    chk("rd_v", rdata_v_o, 1);
    chk("rd_data", rdata_o, 16'h8888);
    chk("rd_yumi_full", core_yumi_o, 0);
    core_rdata_i = 16'h7777; tick();
    chk("rd_held", rdata_o, 16'h8888);
    chk("rd_v_held", rdata_v_o, 1);
    core_v_i = 0;
    chk("rd_busy_no_done", busy_o, 1);
    rdata_yumi_i = 1; tick(); rdata_yumi_i = 0;
    chk("rd_consumed", rdata_v_o, 0);
    chk("rd_yumi_again", core_yumi_o, 1);
    pulse_done();
    chk("rd_busy_done", busy_o, 0);

    // Fill: one write moves into ISSUE, four more fill the queue.
    instr_v_i = 1;
    for (int i = 0; i < 5; i++) begin
      instr_i = mk(WRITE, 4'(i), 4'd0, 4'd0, 4'd0);
      wdata_i = 16'h1111 * 16'(i + 1);
      tick();
      if (i == 3) chk("full_ready_4th", instr_ready_o, 1);
    end
    instr_v_i = 0;
    chk("full_ready_0", instr_ready_o, 0);
    tick();
    chk("full_ready_hold", instr_ready_o, 0);
    cmd_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      exp_wd = 16'h1111 * 16'(i + 1);
      chk("seq_cmd_v", cmd_v_o, 1);
      chk("seq_wdata", w_data_o, exp_wd);
      chk("seq_addrD", addrD_o, 4'(i));
      tick();
      chk("seq_wait", cmd_v_o, 0);
      pulse_done();
      if (i < 4) chk("seq_b2b", cmd_v_o, 1);
      else       chk("seq_idle", busy_o, 0);
      if (i == 0) chk("seq_ready_back", instr_ready_o, 1);
    end
    cmd_ready_i = 0;

    // Illegal op 1011 dropped, add(0,1,2) issued.
    ill0 = ill_cnt;
    instr_v_i = 1; instr_i = mk(4'b1011, 4'd3, 4'd3, 4'd3, 4'd0); tick();
    instr_i = mk(ADD, 4'd0, 4'd2, 4'd1, 4'd0); tick();
    instr_v_i = 0;
    chk("ill_pulse", illegal_o, 1);
    chk("ill_no_issue", cmd_v_o, 0);
    tick();
    chk("ill_pulse_end", illegal_o, 0);
    chk("add_cmd_v", cmd_v_o, 1);
    chk("add_op", op_o, 4'b0000);
    chk("add_addrA", addrA_o, 1);
    chk("add_addrB", addrB_o, 2);
    chk("add_addrD", addrD_o, 0);
    cmd_ready_i = 1; tick(); cmd_ready_i = 0;
    pulse_done();
    chk("ill_count", ill_cnt - ill0, 1);
    chk("add_idle", busy_o, 0);

    // Reset while in WAIT with two queued.
    instr_v_i = 1;
    instr_i = mk(WRITE, 4'd7, 4'd0, 4'd0, 4'd0); wdata_i = 16'hBEEF; tick();
    instr_i = mk(WRITE, 4'd8, 4'd0, 4'd0, 4'd0); wdata_i = 16'h0001; tick();
    instr_i = mk(WRITE, 4'd9, 4'd0, 4'd0, 4'd0); wdata_i = 16'h0002; tick();
    instr_v_i = 0;
    cmd_ready_i = 1; tick(); cmd_ready_i = 0;
    chk("rst_pre_wdata", w_data_o, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", instr_ready_o, 0);
    chk("arst_wdata", w_data_o, 0);
    chk("arst_addrD", addrD_o, 0);
    chk("arst_cmd_v", cmd_v_o, 0);
    chk("arst_yumi", core_yumi_o, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_ready", instr_ready_o, 1);
    chk("post_rst_cmd_v", cmd_v_o, 0);

    // DOT with late done: exactly one handshake until done_i, queued write waits.
    hs0 = hs_cnt;
    cmd_ready_i = 1;
    enq(mk(DOT, 4'd5, 4'd1, 4'd0, 4'd0), 16'h0);
    tick();
    chk("dot_cmd_v", cmd_v_o, 1);
    chk("dot_op", op_o, 4'b1111);
    chk("dot_addrA", addrA_o, 0);
    chk("dot_addrB", addrB_o, 1);
    chk("dot_addrD", addrD_o, 5);
    enq(mk(WRITE, 4'd2, 4'd0, 4'd0, 4'd0), 16'h5A5A);
    repeat (19) tick();
    chk("dot_one_hs", hs_cnt - hs0, 1);
    chk("dot_no_reissue", cmd_v_o, 0);
    chk("dot_busy", busy_o, 1);
    pulse_done();
    chk("dot_next_cmd_v", cmd_v_o, 1);
    chk("dot_next_wdata", w_data_o, 16'h5A5A);
    tick();
    cmd_ready_i = 0;
    pulse_done();
    chk("dot_hs_total", hs_cnt - hs0, 2);
    chk("dot_final_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
